// File: rtl/genius_controller.sv
// Genius memory game controller.
// Moore FSM that sequences the datapath through setup, FPGA sequence playback,
// user input, checking and result display. Its outputs are the datapath
// control strobes. They are decoded from the state register only, so there is
// no combinational path from any input to any output.
module genius_controller (
  input  logic       CLOCK_50,
  input  logic       reset_n,
  input  logic       enter,
  input  logic       end_FPGA,
  input  logic       end_User,
  input  logic       end_time,
  input  logic       win,
  input  logic       match,
  output logic       R1,
  output logic       R2,
  output logic       E1,
  output logic       E2,
  output logic       E3,
  output logic       E4,
  output logic       SEL,
  output logic [3:0] state_o
);

  typedef enum logic [3:0] {
    INIT   = 4'd0,
    SETUP  = 4'd1,
    PREP   = 4'd2,
    SEQ    = 4'd3,
    PLAY   = 4'd4,
    CHECK  = 4'd5,
    NEXT   = 4'd6,
    EVAL   = 4'd7,
    RESULT = 4'd8
  } state_t;

  state_t state_q;
  state_t state_d;
  logic   enter_q;
  logic   enter_ev;

  // A held button advances SETUP/RESULT only once: react to its rising edge.
  assign enter_ev = enter & ~enter_q;

  // State register and enter-edge history, cleared asynchronously by reset.
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= INIT;
      enter_q <= 1'b0;
    end else begin
      state_q <= state_d;
      enter_q <= enter;
    end
  end

  // Next-state logic; unused encodings fall back to INIT.
  always_comb begin
    state_d = INIT;
    case (state_q)
      INIT:    state_d = SETUP;
      SETUP:   state_d = enter_ev ? PREP : SETUP;
      PREP:    state_d = SEQ;
      SEQ:     state_d = end_FPGA ? PLAY : SEQ;
      PLAY: begin
        if (end_time)      state_d = RESULT;
        else if (end_User) state_d = CHECK;
        else               state_d = PLAY;
      end
      CHECK:   state_d = match ? NEXT : RESULT;
      NEXT:    state_d = EVAL;
      // The round counter has already taken the NEXT increment when win is sampled here.
      EVAL:    state_d = win ? RESULT : PREP;
      RESULT:  state_d = enter_ev ? INIT : RESULT;
      default: state_d = INIT;
    endcase
  end

  // Moore output decode from the registered state only.
  always_comb begin
    R1  = 1'b0;
    R2  = 1'b0;
    E1  = 1'b0;
    E2  = 1'b0;
    E3  = 1'b0;
    E4  = 1'b0;
    SEL = 1'b1;
    case (state_q)
      INIT: begin
        R1 = 1'b1;
        R2 = 1'b1;
      end
      SETUP:   E1  = 1'b1;
      PREP:    R2  = 1'b1;
      SEQ:     E3  = 1'b1;
      PLAY:    E2  = 1'b1;
      NEXT:    E4  = 1'b1;
      RESULT:  SEL = 1'b0;
      default: ;
    endcase
  end

  assign state_o = state_q;

endmodule

// File: tb/tb_genius_controller.sv
// Self-checking bench for genius_controller.
// Each task walks the FSM through one scenario. For every cycle it pushes the
// expected outputs to a scoreboard queue, clocks, then pops the entry and
// compares it against the DUT.
module tb_genius_controller;

  localparam logic [3:0] S_INIT   = 4'd0;
  localparam logic [3:0] S_SETUP  = 4'd1;
  localparam logic [3:0] S_PREP   = 4'd2;
  localparam logic [3:0] S_SEQ    = 4'd3;
  localparam logic [3:0] S_PLAY   = 4'd4;
  localparam logic [3:0] S_CHECK  = 4'd5;
  localparam logic [3:0] S_NEXT   = 4'd6;
  localparam logic [3:0] S_EVAL   = 4'd7;
  localparam logic [3:0] S_RESULT = 4'd8;

  logic       clk;
  logic       reset_n;
  logic       enter, end_FPGA, end_User, end_time, win, match;
  logic       R1, R2, E1, E2, E3, E4, SEL;
  logic [3:0] state_o;

  int n_cmp;
  int n_err;
  logic [10:0] sb[$];

  genius_controller dut (
    .CLOCK_50 (clk),
    .reset_n  (reset_n),
    .enter    (enter),
    .end_FPGA (end_FPGA),
    .end_User (end_User),
    .end_time (end_time),
    .win      (win),
    .match    (match),
    .R1       (R1),
    .R2       (R2),
    .E1       (E1),
    .E2       (E2),
    .E3       (E3),
    .E4       (E4),
    .SEL      (SEL),
    .state_o  (state_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected {state, R1, R2, E1, E2, E3, E4, SEL} for a given state code.
  function automatic logic [10:0] model(input logic [3:0] s);
    logic r1, r2, e1, e2, e3, e4, sel;
    r1 = (s == S_INIT);
    r2 = (s == S_INIT) || (s == S_PREP);
    e1 = (s == S_SETUP);
    e2 = (s == S_PLAY);
    e3 = (s == S_SEQ);
    e4 = (s == S_NEXT);
    sel = (s != S_RESULT);
    return {s, r1, r2, e1, e2, e3, e4, sel};
  endfunction

  function automatic logic [10:0] observe();
    return {state_o, R1, R2, E1, E2, E3, E4, SEL};
  endfunction

  // Drive {enter, end_FPGA, end_User, end_time, win, match}.
  task automatic drive(input logic [5:0] v);
    {enter, end_FPGA, end_User, end_time, win, match} = v;
  endtask

  task automatic test_reset();
    logic [10:0] exp, got;
    reset_n = 1'b0;
    drive(6'b0);
    #2;
    sb.push_back(model(S_INIT));
    exp = sb.pop_front(); got = observe(); n_cmp++;
    if (got !== exp) begin
      n_err++; $display("FAIL reset_before_edge: got %h expected %h", got, exp);
    end else $display("reset_before_edge: outputs %h", got);
    @(posedge clk); @(posedge clk); #1;
    sb.push_back(model(S_INIT));
    exp = sb.pop_front(); got = observe(); n_cmp++;
    if (got !== exp) begin
      n_err++; $display("FAIL reset_held: got %h expected %h", got, exp);
    end else $display("reset_held: outputs %h", got);
    reset_n = 1'b1;
    sb.push_back(model(S_SETUP));
    @(posedge clk); #1;
    exp = sb.pop_front(); got = observe(); n_cmp++;
    if (got !== exp) begin
      n_err++; $display("FAIL reset_release: got %h expected %h", got, exp);
    end else $display("reset_release: outputs %h", got);
  endtask

  task automatic test_setup_hold();
    logic [5:0]  stim [12];
    logic [3:0]  es   [12];
    logic [10:0] exp, got;
    for (int i = 0; i < 12; i++) begin
      stim[i] = (i < 10) ? 6'b100000 : 6'b000000;
      es[i]   = (i == 0) ? S_PREP : S_SEQ;
    end
    for (int i = 0; i < 12; i++) begin
      drive(stim[i]);
      sb.push_back(model(es[i]));
      @(posedge clk); #1;
      exp = sb.pop_front(); got = observe(); n_cmp++;
      if (got !== exp) begin
        n_err++; $display("FAIL setup_hold[%0d]: got %h expected %h", i, got, exp);
      end else $display("setup_hold[%0d]: outputs %h", i, got);
    end
  endtask

  task automatic test_round();
    logic [5:0]  stim [8];
    logic [3:0]  es   [8];
    logic [10:0] exp, got;
    stim = '{6'b010000, 6'b000000, 6'b001001, 6'b000001,
             6'b000000, 6'b000000, 6'b000000, 6'b000000};
    es   = '{S_PLAY, S_PLAY, S_CHECK, S_NEXT, S_EVAL, S_PREP, S_SEQ, S_SEQ};
    for (int i = 0; i < 8; i++) begin
      drive(stim[i]);
      sb.push_back(model(es[i]));
      @(posedge clk); #1;
      exp = sb.pop_front(); got = observe(); n_cmp++;
      if (got !== exp) begin
        n_err++; $display("FAIL round[%0d]: got %h expected %h", i, got, exp);
      end else $display("round[%0d]: outputs %h", i, got);
    end
  endtask

  task automatic test_timeout_priority();
    logic [5:0]  stim [4];
    logic [3:0]  es   [4];
    logic [10:0] exp, got;
    stim = '{6'b010000, 6'b001100, 6'b001101, 6'b000000};
    es   = '{S_PLAY, S_RESULT, S_RESULT, S_RESULT};
    for (int i = 0; i < 4; i++) begin
      drive(stim[i]);
      sb.push_back(model(es[i]));
      @(posedge clk); #1;
      exp = sb.pop_front(); got = observe(); n_cmp++;
      if (got !== exp) begin
        n_err++; $display("FAIL timeout[%0d]: got %h expected %h", i, got, exp);
      end else $display("timeout[%0d]: outputs %h", i, got);
    end
  endtask

  task automatic test_result_exit();
    logic [5:0]  stim [6];
    logic [3:0]  es   [6];
    logic [10:0] exp, got;
    stim = '{6'b100000, 6'b100000, 6'b100000, 6'b000000, 6'b100000, 6'b000000};
    es   = '{S_INIT, S_SETUP, S_SETUP, S_SETUP, S_PREP, S_SEQ};
    for (int i = 0; i < 6; i++) begin
      drive(stim[i]);
      sb.push_back(model(es[i]));
      @(posedge clk); #1;
      exp = sb.pop_front(); got = observe(); n_cmp++;
      if (got !== exp) begin
        n_err++; $display("FAIL result_exit[%0d]: got %h expected %h", i, got, exp);
      end else $display("result_exit[%0d]: outputs %h", i, got);
    end
  endtask

  task automatic test_mismatch_and_win();
    logic [5:0]  stim [13];
    logic [3:0]  es   [13];
    logic [10:0] exp, got;
    stim = '{6'b010000, 6'b001000, 6'b000000, 6'b100000, 6'b000000,
             6'b100000, 6'b000000, 6'b010000, 6'b001001, 6'b000001,
             6'b000010, 6'b000010, 6'b000000};
    es   = '{S_PLAY, S_CHECK, S_RESULT, S_INIT, S_SETUP,
             S_PREP, S_SEQ, S_PLAY, S_CHECK, S_NEXT,
             S_EVAL, S_RESULT, S_RESULT};
    for (int i = 0; i < 13; i++) begin
      drive(stim[i]);
      sb.push_back(model(es[i]));
      @(posedge clk); #1;
      exp = sb.pop_front(); got = observe(); n_cmp++;
      if (got !== exp) begin
        n_err++; $display("FAIL mismatch_win[%0d]: got %h expected %h", i, got, exp);
      end else $display("mismatch_win[%0d]: outputs %h", i, got);
    end
  endtask

  task automatic test_reset_in_play();
    logic [5:0]  stim [6];
    logic [3:0]  es   [6];
    logic [10:0] exp, got;
    stim = '{6'b100000, 6'b000000, 6'b100000, 6'b000000, 6'b010000, 6'b000000};
    es   = '{S_INIT, S_SETUP, S_PREP, S_SEQ, S_PLAY, S_PLAY};
    for (int i = 0; i < 6; i++) begin
      drive(stim[i]);
      sb.push_back(model(es[i]));
      @(posedge clk); #1;
      exp = sb.pop_front(); got = observe(); n_cmp++;
      if (got !== exp) begin
        n_err++; $display("FAIL reach_play[%0d]: got %h expected %h", i, got, exp);
      end else $display("reach_play[%0d]: outputs %h", i, got);
    end
    // Mid-cycle reset: no clock edge between assertion and the check.
    #2;
    reset_n = 1'b0;
    sb.push_back(model(S_INIT));
    #1;
    exp = sb.pop_front(); got = observe(); n_cmp++;
    if (got !== exp) begin
      n_err++; $display("FAIL async_reset_play: got %h expected %h", got, exp);
    end else $display("async_reset_play: outputs %h", got);
    @(posedge clk); #3;
    reset_n = 1'b1;
    sb.push_back(model(S_SETUP));
    @(posedge clk); #1;
    exp = sb.pop_front(); got = observe(); n_cmp++;
    if (got !== exp) begin
      n_err++; $display("FAIL release_after_play: got %h expected %h", got, exp);
    end else $display("release_after_play: outputs %h", got);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    test_reset();
    test_setup_hold();
    test_round();
    test_timeout_priority();
    test_result_exit();
    test_mismatch_and_win();
    test_reset_in_play();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Watchdog so the run always ends on its own.
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
